branch_predict_unit: RTL and testbench



---
 rtl/branch_predict_unit_pkg.sv | 60 ++++++
 rtl/branch_predict_unit_bht_table.sv | 38 +++
 rtl/branch_predict_unit.sv | 165 ++++++++++++++++
 tb/tb_branch_predict_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit.
// Contents:
//   - PC mux select codes: NO_BRANCH, BRANCH, JALR, PC_RECOVER
//   - jorbranch codes from the control unit: JB_OTHER, JB_BRANCH, JB_JAL, JB_JALR
//   - BR_* branch_type codes (funct3 encoding)
//   - FSM state type (BPU_IDLE / BPU_FLUSH)
//   - helper functions: branch condition evaluation, 2-bit saturating update
// Optional build macro used by the top: BPU_STATS_EN (adds statistics counters).
package branch_predict_unit_pkg;

  localparam logic [1:0] NO_BRANCH  = 2'b00;
  localparam logic [1:0] BRANCH     = 2'b01;
  localparam logic [1:0] JALR       = 2'b10;
  localparam logic [1:0] PC_RECOVER = 2'b11;

  localparam logic [1:0] JB_OTHER  = 2'b00;
  localparam logic [1:0] JB_BRANCH = 2'b01;
  localparam logic [1:0] JB_JAL    = 2'b10;
  localparam logic [1:0] JB_JALR   = 2'b11;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic {
    BPU_IDLE  = 1'b0,
    BPU_FLUSH = 1'b1
  } bpu_state_t;

  // Flag convention of the ALU compare: cf=1 means no borrow (a >= b unsigned).
  function automatic logic branch_taken(input logic [2:0] br_type,
                                        input logic cf, input logic zf,
                                        input logic vf, input logic sf);
    logic t;
    case (br_type)
      BR_BEQ:  t = zf;
      BR_BNE:  t = ~zf;
      BR_BLT:  t = (sf != vf);
      BR_BGE:  t = (sf == vf);
      BR_BLTU: t = ~cf;
      BR_BGEU: t = cf;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] n;
    if (taken) begin
      n = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      n = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht_table.sv
// bht_table: direct-mapped array of 2-bit saturating counters.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (all entries -> CNT_INIT)
//   rd_idx / rd_cnt   combinational read port (value before any same-edge write)
//   wr_en, wr_idx,
//   wr_taken          saturating increment (taken) / decrement (not taken) at clk edge
module bht_table
  import branch_predict_unit_pkg::*;
#(
  parameter int          BHT_ENTRIES = 64,
  parameter logic [1:0]  CNT_INIT    = 2'b01,
  localparam int         IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt [BHT_ENTRIES];

  assign rd_cnt = cnt[rd_idx];

  // Counter array: reinitialised by reset, one saturating update per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        cnt[i] <= CNT_INIT;
      end
    end else if (wr_en) begin
      cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BHT lookup at fetch, branch/jump resolution in EX,
// PC mux selection and a counted pipeline flush after every redirect.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_pc / if_pred_taken    fetch lookup (combinational, counter MSB)
//   ex_valid, ex_pc          EX instruction valid and PC
//   jorbranch, branch_type   control-unit class and branch condition code
//   cf, zf, vf, sf           ALU flags of the EX compare
//   ex_pred_taken            prediction that travelled with the EX instruction
//   pc_mux_ctrl, mispredict  combinational redirect this cycle
//   flush                    registered squash of IF/ID and ID/EX
// Build macro BPU_STATS_EN adds stat_branches / stat_mispredicts outputs.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         PC_W         = 32,
  parameter int         BHT_ENTRIES  = 64,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] CNT_INIT     = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [1:0]      jorbranch,
  input  logic [2:0]      branch_type,
  input  logic            cf,
  input  logic            zf,
  input  logic            vf,
  input  logic            sf,
  input  logic            ex_pred_taken,
  output logic [1:0]      pc_mux_ctrl,
  output logic            flush,
  output logic            mispredict
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bpu_state_t state;
  logic [2:0] flush_cnt;
  logic [1:0] rd_cnt;
  logic       taken;
  logic       resolve;
  logic       bht_wr;

  // PC bits outside the index field are intentionally ignored (no tags).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  assign taken   = branch_taken(branch_type, cf, zf, vf, sf);
  // EX contents are squashed while flushing, so nothing resolves then.
  assign resolve = ex_valid && (state == BPU_IDLE);
  assign bht_wr  = resolve && (jorbranch == JB_BRANCH);

  bht_table #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .CNT_INIT    (CNT_INIT)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_cnt   (rd_cnt),
    .wr_en    (bht_wr),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign if_pred_taken = rd_cnt[1];

  // Redirect decision; jumps are never predicted so they always redirect.
  always_comb begin
    pc_mux_ctrl = NO_BRANCH;
    mispredict  = 1'b0;
    if (resolve) begin
      case (jorbranch)
        JB_BRANCH: begin
          if (taken && !ex_pred_taken) begin
            pc_mux_ctrl = BRANCH;
            mispredict  = 1'b1;
          end else if (!taken && ex_pred_taken) begin
            pc_mux_ctrl = PC_RECOVER;
            mispredict  = 1'b1;
          end else begin
            pc_mux_ctrl = NO_BRANCH;
            mispredict  = 1'b0;
          end
        end
        JB_JAL: begin
          pc_mux_ctrl = BRANCH;
          mispredict  = 1'b1;
        end
        JB_JALR: begin
          pc_mux_ctrl = JALR;
          mispredict  = 1'b1;
        end
        default: begin
          pc_mux_ctrl = NO_BRANCH;
          mispredict  = 1'b0;
        end
      endcase
    end else begin
      pc_mux_ctrl = NO_BRANCH;
      mispredict  = 1'b0;
    end
  end

  // Flush FSM: flush stays high for FLUSH_CYCLES cycles after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BPU_IDLE;
      flush_cnt <= 3'd0;
      flush     <= 1'b0;
    end else begin
      case (state)
        BPU_IDLE: begin
          if (mispredict) begin
            state     <= BPU_FLUSH;
            flush_cnt <= 3'(FLUSH_CYCLES - 1);
            flush     <= 1'b1;
          end
        end
        BPU_FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state <= BPU_IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
            flush     <= 1'b1;
          end
        end
        default: begin
          state     <= BPU_IDLE;
          flush_cnt <= 3'd0;
          flush     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BPU_STATS_EN
  // Statistics: resolved conditional branches and resolved redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (bht_wr) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (default parameters).
// A behavioural model (integer counters, remaining-flush count) predicts the
// outputs every cycle; directed steps add hand-computed literal expectations.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int N  = 64;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  jorbranch;
  logic [2:0]  branch_type;
  logic        cf, zf, vf, sf;
  logic        ex_pred_taken;
  logic [1:0]  pc_mux_ctrl;
  logic        flush;
  logic        mispredict;
`ifdef BPU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predict_unit dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .jorbranch     (jorbranch),
    .branch_type   (branch_type),
    .cf            (cf),
    .zf            (zf),
    .vf            (vf),
    .sf            (sf),
    .ex_pred_taken (ex_pred_taken),
    .pc_mux_ctrl   (pc_mux_ctrl),
    .flush         (flush),
    .mispredict    (mispredict)
`ifdef BPU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int model_cnt [N];
  int flush_left;
  int m_br;
  int m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit cond_true(input logic [2:0] t);
    case (t)
      3'd0: return zf == 1'b1;
      3'd1: return zf == 1'b0;
      3'd4: return sf != vf;
      3'd5: return sf == vf;
      3'd6: return cf == 1'b0;
      3'd7: return cf == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model_cnt[i] = 1;
    flush_left = 0;
    m_br = 0;
    m_mis = 0;
  endtask

  task automatic expect_outputs(output logic [1:0] em, output bit emis,
                                output bit eupd, output bit et);
    em = 2'd0; emis = 1'b0; eupd = 1'b0; et = 1'b0;
    if (ex_valid && flush_left == 0) begin
      if (jorbranch == 2'd1) begin
        et = cond_true(branch_type);
        eupd = 1'b1;
        if (et && !ex_pred_taken) begin em = 2'd1; emis = 1'b1; end
        else if (!et && ex_pred_taken) begin em = 2'd3; emis = 1'b1; end
      end else if (jorbranch == 2'd2) begin
        em = 2'd1; emis = 1'b1;
      end else if (jorbranch == 2'd3) begin
        em = 2'd2; emis = 1'b1;
      end
    end
  endtask

  // One clock: compare at negedge against the model, then advance the model.
  task automatic step();
    logic [1:0] em;
    bit emis, eupd, et;
    int k;
    @(negedge clk);
    expect_outputs(em, emis, eupd, et);
    check("pred", 32'(if_pred_taken), 32'(model_cnt[idx(if_pc)] >= 2));
    check("pc_mux_ctrl", 32'(pc_mux_ctrl), 32'(em));
    check("mispredict", 32'(mispredict), 32'(emis));
    check("flush", 32'(flush), 32'(flush_left > 0));
`ifdef BPU_STATS_EN
    check("stat_branches", stat_branches, 32'(m_br));
    check("stat_mispredicts", stat_mispredicts, 32'(m_mis));
`endif
    if (flush_left > 0) flush_left--;
    else if (emis) flush_left = FC;
    if (eupd) begin
      k = idx(ex_pc);
      if (et) model_cnt[k] = (model_cnt[k] == 3) ? 3 : model_cnt[k] + 1;
      else    model_cnt[k] = (model_cnt[k] == 0) ? 0 : model_cnt[k] - 1;
      m_br++;
    end
    if (emis) m_mis++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic [1:0] jb,
                        input logic [2:0] bt, input logic [3:0] flags, input logic pred);
    ex_valid = v; ex_pc = pc; jorbranch = jb; branch_type = bt;
    {cf, zf, vf, sf} = flags;
    ex_pred_taken = pred;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    set_ex(1'b0, 32'h0, 2'd0, 3'd0, 4'h0, 1'b0);
    model_reset();
    #12;
    check("reset_pred", 32'(if_pred_taken), 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_mux", 32'(pc_mux_ctrl), 32'(NO_BRANCH));
    check("reset_mis", 32'(mispredict), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // BEQ taken, predicted not taken -> BRANCH, 2-cycle flush, counter 1->2
    set_ex(1'b1, 32'h40, JB_BRANCH, BR_BEQ, 4'b0100, 1'b0);
    #1;
    check("beq_mux", 32'(pc_mux_ctrl), 32'(BRANCH));
    check("beq_mis", 32'(mispredict), 32'd1);
    step();
    ex_valid = 1'b0;
    if_pc = 32'h40;
    #1;
    check("beq_flush1", 32'(flush), 32'd1);
    check("beq_pred_after", 32'(if_pred_taken), 32'd1);
    step();
    check("beq_flush2", 32'(flush), 32'd1);
    step();
    check("beq_flush_end", 32'(flush), 32'd0);

    // BLTU with cf=1 is not taken; predicted taken -> PC_RECOVER, counter 2->1
    set_ex(1'b1, 32'h40, JB_BRANCH, BR_BLTU, 4'b1000, 1'b1);
    #1;
    check("bltu_mux", 32'(pc_mux_ctrl), 32'(PC_RECOVER));
    check("bltu_mis", 32'(mispredict), 32'd1);
    step();
    // Resolve presented during flush is ignored
    set_ex(1'b1, 32'h40, JB_BRANCH, BR_BEQ, 4'b0100, 1'b0);
    #1;
    check("flush_ignore_mux", 32'(pc_mux_ctrl), 32'(NO_BRANCH));
    check("flush_ignore_mis", 32'(mispredict), 32'd0);
    step();
    step();
    ex_valid = 1'b0;
    #1;
    check("bltu_pred_after", 32'(if_pred_taken), 32'd0);

    // Four correctly predicted taken BGEs on 0x80 saturate the counter
    if_pc = 32'h80;
    set_ex(1'b1, 32'h80, JB_BRANCH, BR_BGE, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bge_noflush", 32'(flush), 32'd0);
    end
    ex_valid = 1'b0;
    #1;
    check("bge_sat_pred", 32'(if_pred_taken), 32'd1);
    check("bge_sat_model", 32'(model_cnt[32]), 32'd3);
    // One not-taken BGE: 3->2, still predicts taken
    set_ex(1'b1, 32'h80, JB_BRANCH, BR_BGE, 4'b0001, 1'b1);
    step();
    ex_valid = 1'b0;
    #1;
    check("bge_nt_pred", 32'(if_pred_taken), 32'd1);
    step();
    step();

    // JALR: redirect, BHT untouched, same-cycle lookup sees current value
    set_ex(1'b1, 32'h80, JB_JALR, BR_BEQ, 4'b0100, 1'b0);
    #1;
    check("jalr_mux", 32'(pc_mux_ctrl), 32'(JALR));
    check("jalr_pred_same", 32'(if_pred_taken), 32'd1);
    step();
    ex_valid = 1'b0;
    #1;
    check("jalr_flush", 32'(flush), 32'd1);
    check("jalr_bht_kept", 32'(if_pred_taken), 32'd1);
`ifdef BPU_STATS_EN
    check("stats_br_total", stat_branches, 32'd7);
    check("stats_mis_total", stat_mispredicts, 32'd4);
`endif

    // Reset mid-flush: flush drops at once, BHT back to weakly not-taken
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_flush", 32'(flush), 32'd0);
    check("rst_pred_80", 32'(if_pred_taken), 32'd0);
`ifdef BPU_STATS_EN
    check("rst_stat_br", stat_branches, 32'd0);
    check("rst_stat_mis", stat_mispredicts, 32'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if_pc = 32'(i) << 2;
      step();
    end

    // Randomized traffic over a few aliased indices
    for (int n = 0; n < 600; n++) begin
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_pc         = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2)
                      | 32'($urandom_range(0, 3));
      jorbranch     = 2'($urandom_range(0, 3));
      branch_type   = 3'($urandom_range(0, 7));
      {cf, zf, vf, sf} = 4'($urandom_range(0, 15));
      ex_pred_taken = 1'($urandom_range(0, 1));
      if_pc         = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
      step();
    end

    // Final sweep of every entry
    ex_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if_pc = 32'(i) << 2;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
